// File: rtl/sid_i2s_out.sv
// sid_i2s_out: audio output stage for the SID filter pipeline.
// Holds the most recent left/right sample (power-of-two gain with
// saturation to 24 bits) and serializes it as a 64-BCLK I2S frame
// (32-bit slots, 24 significant bits, one-BCLK data delay).
//
// state      | meaning
// -----------+------------------------------------------------------
// bit_cnt=0  | left slot, previous frame's last (padding) bit on sd
// bit_cnt<32 | left slot, lrclk=0, left MSB first at bit_cnt=1
// bit_cnt>=32| right slot, lrclk=1, right MSB first at bit_cnt=33
// 63 -> 0    | frame load: shifter takes the hold registers
module sid_i2s_out #(
  parameter int CLK_DIV    = 4,
  parameter int GAIN_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [23:0] audio_l,
  input  logic signed [23:0] audio_r,
  input  logic               audio_valid,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sd,
  output logic               frame_o,
  output logic               repeat_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_next;
  logic [23:0] hold_l;
  logic [23:0] hold_r;
  logic [63:0] shifter;
  logic        fresh;
  logic        div_wrap;
  logic        bclk_fall;
  logic        frame_load;

  // Gain is applied in 31 bits so the largest shift (7) cannot overflow
  // before the clamp to the 24-bit range.
  function automatic logic [23:0] sat24(input logic signed [23:0] x);
    logic signed [30:0] wide;
    wide = {{7{x[23]}}, x};
    wide = wide <<< GAIN_SHIFT;
    if (wide > 31'sd8388607)
      return 24'h7FFFFF;
    else if (wide < -31'sd8388608)
      return 24'h800000;
    else
      return wide[23:0];
  endfunction

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign bclk_fall  = div_wrap && i2s_bclk;
  assign frame_load = bclk_fall && (bit_cnt == 6'd63);
  assign bit_next   = bit_cnt + 6'd1;

  // BCLK generation: toggle every CLK_DIV system clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= 8'd0;
      i2s_bclk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= 8'd0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + 8'd1;
    end
  end

  // Frame sequencing: bit counter, word select, shifter and serial data
  // all move together on BCLK falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 6'd0;
      i2s_lrclk <= 1'b0;
      i2s_sd    <= 1'b0;
      shifter   <= 64'd0;
      frame_o   <= 1'b0;
      repeat_o  <= 1'b0;
    end else begin
      frame_o  <= 1'b0;
      repeat_o <= 1'b0;
      if (bclk_fall) begin
        bit_cnt   <= bit_next;
        i2s_lrclk <= bit_next[5];
        // The bit leaving the top is always one BCLK behind the counter,
        // which gives the I2S one-bit delay after each LRCLK edge.
        i2s_sd    <= shifter[63];
        if (frame_load) begin
          shifter  <= {hold_l, 8'h00, hold_r, 8'h00};
          frame_o  <= 1'b1;
          repeat_o <= ~fresh;
        end else begin
          shifter  <= {shifter[62:0], 1'b0};
        end
      end
    end
  end

  // Sample capture; a sample landing in the load cycle wins over the clear
  // so it is marked fresh for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_l <= 24'd0;
      hold_r <= 24'd0;
      fresh  <= 1'b0;
    end else if (audio_valid) begin
      hold_l <= sat24(audio_l);
      hold_r <= sat24(audio_r);
      fresh  <= 1'b1;
    end else if (frame_load) begin
      fresh  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sid_i2s_out.sv
// Directed bench for sid_i2s_out: two instances (gain 0 and gain 2) share
// clock and reset; a monitor reassembles each serialized 64-bit frame.
module tb_sid_i2s_out;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [23:0] a_l = '0;
  logic signed [23:0] a_r = '0;
  logic               a_v = 1'b0;
  logic signed [23:0] g_l = '0;
  logic signed [23:0] g_r = '0;
  logic               g_v = 1'b0;
  logic bclk, lrclk, sd, frame_o, repeat_o;
  logic g_bclk, g_lrclk, g_sd, g_frame, g_repeat;

  int checks   = 0;
  int failures = 0;

  logic [63:0] frames_q[$];
  logic [63:0] g_frames_q[$];
  logic        rep_q[$];

  int cyc = 0;
  int last_rise = 0, last_lrf = 0, last_fr = 0;
  int bclk_per = 0, bclk_hi = 0, lr_per = 0, lr_low = 0, frame_per = 0;
  logic bclk_q = 0, lr_q = 0, prev_lr = 0, g_bclk_q = 0, g_prev_lr = 0;
  logic [63:0] sh = '0, g_sh = '0;

  always #5 clk = ~clk;

  sid_i2s_out #(.CLK_DIV(4), .GAIN_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .audio_l(a_l), .audio_r(a_r), .audio_valid(a_v),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sd(sd),
    .frame_o(frame_o), .repeat_o(repeat_o)
  );

  sid_i2s_out #(.CLK_DIV(4), .GAIN_SHIFT(2)) dut_g (
    .clk(clk), .rst(rst), .audio_l(g_l), .audio_r(g_r), .audio_valid(g_v),
    .i2s_bclk(g_bclk), .i2s_lrclk(g_lrclk), .i2s_sd(g_sd),
    .frame_o(g_frame), .repeat_o(g_repeat)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] frm(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  // Monitor on the falling system clock edge: rebuilds frames from sd at
  // every BCLK rise and times the BCLK/LRCLK/frame_o edges.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      bclk_q = 0; lr_q = 0; prev_lr = 0; sh = '0;
      g_bclk_q = 0; g_prev_lr = 0; g_sh = '0;
    end else begin
      cyc++;
      if (bclk && !bclk_q) begin
        sh = {sh[62:0], sd};
        if (!lrclk && prev_lr) frames_q.push_back(sh);
        prev_lr   = lrclk;
        bclk_per  = cyc - last_rise;
        last_rise = cyc;
      end
      if (!bclk && bclk_q) bclk_hi = cyc - last_rise;
      if (!lrclk && lr_q) begin
        lr_per   = cyc - last_lrf;
        last_lrf = cyc;
      end
      if (lrclk && !lr_q) lr_low = cyc - last_lrf;
      if (frame_o) begin
        rep_q.push_back(repeat_o);
        frame_per = cyc - last_fr;
        last_fr   = cyc;
      end
      bclk_q = bclk;
      lr_q   = lrclk;
      if (g_bclk && !g_bclk_q) begin
        g_sh = {g_sh[62:0], g_sd};
        if (!g_lrclk && g_prev_lr) g_frames_q.push_back(g_sh);
        g_prev_lr = g_lrclk;
      end
      g_bclk_q = g_bclk;
    end
  end

  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    a_l = l; a_r = r; a_v = 1'b1;
    @(posedge clk); #1;
    a_v = 1'b0;
  endtask

  task automatic strobe_g(input logic [23:0] l, input logic [23:0] r);
    g_l = l; g_r = r; g_v = 1'b1;
    @(posedge clk); #1;
    g_v = 1'b0;
  endtask

  task automatic wait_frame_o(input string tag);
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!frame_o && t < 2000);
    chk({tag, "_frame_seen"}, 64'(frame_o), 64'd1);
  endtask

  task automatic sync_frame(input string tag);
    wait_frame_o(tag);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic wait_caps(input int n, input string tag);
    int t = 0;
    while (frames_q.size() < n && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_captured"}, 64'(frames_q.size() >= n), 64'd1);
  endtask

  task automatic wait_gcaps(input int n, input string tag);
    int t = 0;
    while (g_frames_q.size() < n && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_captured"}, 64'(g_frames_q.size() >= n), 64'd1);
  endtask

  task automatic wait_events(input int n, input string tag);
    int t = 0;
    while (rep_q.size() < n && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_events"}, 64'(rep_q.size() >= n), 64'd1);
  endtask

  // Release reset (called at posedge+1) and time the first BCLK rise and the
  // number of BCLK falls up to the first frame_o.
  task automatic release_check(input string tag);
    int   n = 0;
    int   first = -1;
    int   falls = 0;
    logic bq;
    bq  = bclk;
    rst = 1'b0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (bclk && !bq && first < 0) first = n;
      if (!bclk && bq) falls++;
      bq = bclk;
      if (frame_o) break;
    end
    chk({tag, "_first_rise"}, 64'(first), 64'd4);
    chk({tag, "_falls_to_frame"}, 64'(falls), 64'd64);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    int   falls;
    int   t;
    logic bq;
    logic [23:0] sat_l [3] = '{24'h300000, 24'h001234, 24'hE00000};
    logic [23:0] sat_r [3] = '{24'hD00000, 24'hFFF000, 24'h200000};
    logic [23:0] exp_l [3] = '{24'h7FFFFF, 24'h0048D0, 24'h800000};
    logic [23:0] exp_r [3] = '{24'h800000, 24'hFFC000, 24'h7FFFFF};

    // reset values and clock timing
    repeat (3) @(posedge clk);
    #1;
    chk("por_out", 64'({bclk, lrclk, sd, frame_o, repeat_o}), 64'd0);
    chk("por_out_g", 64'({g_bclk, g_lrclk, g_sd, g_frame, g_repeat}), 64'd0);
    release_check("por");
    wait_events(3, "clocks");
    chk("bclk_period", 64'(bclk_per), 64'd8);
    chk("bclk_high", 64'(bclk_hi), 64'd4);
    chk("lrclk_period", 64'(lr_per), 64'd512);
    chk("lrclk_low", 64'(lr_low), 64'd256);
    chk("frame_period", 64'(frame_per), 64'd512);
    chk("por_repeat", 64'(rep_q[0]), 64'd1);

    // slot alignment with full-scale values
    sync_frame("align");
    c = rep_q.size();
    strobe(24'h7FFFFF, 24'h800000);
    wait_caps(c + 2, "align");
    chk("align_frame", frames_q[c+1], frm(24'h7FFFFF, 24'h800000));
    chk("align_repeat", 64'(rep_q[c]), 64'd0);

    // one sample, then three frames without audio_valid
    sync_frame("rep");
    c = rep_q.size();
    strobe(24'h123456, 24'h123456);
    wait_caps(c + 4, "rep");
    for (int i = 1; i <= 3; i++)
      chk($sformatf("rep_frame%0d", i), frames_q[c+i], frm(24'h123456, 24'h123456));
    chk("rep_flag1", 64'(rep_q[c]), 64'd0);
    chk("rep_flag2", 64'(rep_q[c+1]), 64'd1);
    chk("rep_flag3", 64'(rep_q[c+2]), 64'd1);

    // sample arriving exactly in the load cycle
    sync_frame("coin");
    c = rep_q.size();
    strobe(24'h000555, 24'h000555);
    wait_frame_o("coin_first");
    repeat (511) @(posedge clk);
    #1;
    a_l = 24'h000AAA; a_r = 24'h000AAA; a_v = 1'b1;
    @(posedge clk); #1;
    a_v = 1'b0;
    chk("coin_in_load_cycle", 64'(frame_o), 64'd1);
    wait_caps(c + 4, "coin");
    chk("coin_cur_frame", frames_q[c+2], frm(24'h000555, 24'h000555));
    chk("coin_next_frame", frames_q[c+3], frm(24'h000AAA, 24'h000AAA));
    chk("coin_cur_repeat", 64'(rep_q[c+1]), 64'd1);
    chk("coin_next_repeat", 64'(rep_q[c+2]), 64'd0);

    // gain of 4 with saturation on the second instance
    for (int k = 0; k < 3; k++) begin
      sync_frame("sat");
      c = g_frames_q.size();
      strobe_g(sat_l[k], sat_r[k]);
      wait_gcaps(c + 2, "sat");
      chk($sformatf("sat_frame%0d", k), g_frames_q[c+1], frm(exp_l[k], exp_r[k]));
    end

    // reset at bit counter 40
    wait_frame_o("mid");
    bq    = bclk;
    falls = 0;
    t     = 0;
    while (falls < 40 && t < 2000) begin
      @(posedge clk); #1;
      t++;
      if (bq && !bclk) falls++;
      bq = bclk;
    end
    chk("mid_pre_lrclk", 64'(lrclk), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_async_out", 64'({bclk, lrclk, sd, frame_o, repeat_o}), 64'd0);
    frames_q.delete();
    g_frames_q.delete();
    rep_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_held_out", 64'({bclk, lrclk, sd, frame_o, repeat_o}), 64'd0);
    release_check("mid");
    wait_caps(2, "mid");
    chk("mid_frame0", frames_q[0], 64'd0);
    chk("mid_frame1", frames_q[1], 64'd0);
    chk("mid_repeat", 64'(rep_q[0]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
